// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scan_pkg
// Brief   : Shared state encoding and default sizing for the threshold scan.
// Revision: 1.0
// ============================================================================
package scan_pkg;

    localparam int c_code_w     = 12;
    localparam int c_cnt_w      = 32;
    localparam int c_settle_cyc = 500;
    localparam int c_dac_tmo    = 4096;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD     = 4'd1,
        S_WAIT_DAC = 4'd2,
        S_SETTLE   = 4'd3,
        S_CLEAR    = 4'd4,
        S_GATE     = 4'd5,
        S_SAMPLE   = 4'd6,
        S_REPORT   = 4'd7,
        S_NEXT     = 4'd8
    } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module  : scan_timer
// Brief   : Loadable down-counter with zero flag, shared by all timed phases.
// Revision: 1.0
// ============================================================================
module scan_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : scan_sequencer
// Brief   : Steps the DAC code across a range, gating the counter per point
//           and handing (code, count) results out over valid/ready.
// Revision: 1.0
// ============================================================================
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int CODE_W     = c_code_w,
    parameter int CNT_W      = c_cnt_w,
    parameter int SETTLE_CYC = c_settle_cyc,
    parameter int DAC_TMO    = c_dac_tmo
) (
    input  logic              clock50Mhz,
    input  logic              key_restart,
    input  logic [CODE_W-1:0] cfg_start,
    input  logic [CODE_W-1:0] cfg_stop,
    input  logic [CODE_W-1:0] cfg_step,
    input  logic [CNT_W-1:0]  cfg_window,
    input  logic              start,
    input  logic              abort,
    output logic [CODE_W-1:0] dac_code,
    output logic              dac_load,
    input  logic              dac_done,
    output logic              cnt_clear,
    output logic              cnt_gate,
    input  logic [CNT_W-1:0]  cnt_value,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CODE_W-1:0] res_code,
    output logic [CNT_W-1:0]  res_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    scan_state_e       r_state;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] r_stop;
    logic [CODE_W-1:0] r_step;
    logic [CNT_W-1:0]  r_window;
    logic              r_err;
    logic              r_done;
    logic              r_res_valid;
    logic [CODE_W-1:0] r_res_code;
    logic [CNT_W-1:0]  r_res_count;

    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_val;
    logic              w_tmr_en;
    logic              w_tmr_zero;
    logic [CODE_W:0]   w_next;
    logic              w_next_ok;

    // One extra bit so a step past the top of the code range is seen as "beyond stop".
    assign w_next    = {1'b0, r_code} + {1'b0, r_step};
    assign w_next_ok = (w_next <= {1'b0, r_stop});

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_en   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = CNT_W'(DAC_TMO - 1);
            end
            S_WAIT_DAC: begin
                if (dac_done) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(SETTLE_CYC - 1);
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            S_SETTLE: w_tmr_en = 1'b1;
            S_CLEAR: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = r_window - 1'b1;
            end
            S_GATE:   w_tmr_en = 1'b1;
            default:  w_tmr_en = 1'b0;
        endcase
    end

    scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clock50Mhz),
        .rst_n      (key_restart),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            r_state     <= S_IDLE;
            r_code      <= '0;
            r_stop      <= '0;
            r_step      <= '0;
            r_window    <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_code  <= '0;
            r_res_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_res_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_stop   <= cfg_stop;
                            r_step   <= (cfg_step == '0) ? CODE_W'(1) : cfg_step;
                            r_window <= (cfg_window == '0) ? CNT_W'(1) : cfg_window;
                            if (cfg_start > cfg_stop) begin
                                r_err  <= 1'b1;
                                r_done <= 1'b1;
                            end else begin
                                r_err   <= 1'b0;
                                r_code  <= cfg_start;
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: r_state <= S_WAIT_DAC;
                    S_WAIT_DAC: begin
                        if (dac_done) begin
                            r_state <= S_SETTLE;
                        end else if (w_tmr_zero) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_SETTLE: if (w_tmr_zero) r_state <= S_CLEAR;
                    S_CLEAR:  r_state <= S_GATE;
                    S_GATE:   if (w_tmr_zero) r_state <= S_SAMPLE;
                    S_SAMPLE: begin
                        r_res_code  <= r_code;
                        r_res_count <= cnt_value;
                        r_res_valid <= 1'b1;
                        r_state     <= S_REPORT;
                    end
                    S_REPORT: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            r_state     <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (w_next_ok) begin
                            r_code  <= w_next[CODE_W-1:0];
                            r_state <= S_LOAD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign dac_code  = r_code;
    assign dac_load  = (r_state == S_LOAD);
    assign cnt_clear = (r_state == S_CLEAR);
    assign cnt_gate  = (r_state == S_GATE);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign res_valid = r_res_valid;
    assign res_code  = r_res_code;
    assign res_count = r_res_count;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_scan_sequencer
// Brief   : Directed vector bench for scan_sequencer with DAC/counter models.
// Revision: 1.0
// ============================================================================
module tb_scan_sequencer;

    localparam int CODE_W     = 12;
    localparam int CNT_W      = 32;
    localparam int SETTLE_CYC = 5;
    localparam int DAC_TMO    = 64;
    localparam int DAC_DLY    = 20;

    logic              clk = 1'b0;
    logic              key_restart = 1'b0;
    logic [CODE_W-1:0] cfg_start = '0;
    logic [CODE_W-1:0] cfg_stop = '0;
    logic [CODE_W-1:0] cfg_step = '0;
    logic [CNT_W-1:0]  cfg_window = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CODE_W-1:0] dac_code;
    logic              dac_load;
    logic              dac_done = 1'b0;
    logic              cnt_clear;
    logic              cnt_gate;
    logic [CNT_W-1:0]  cnt_value = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [CODE_W-1:0] res_code;
    logic [CNT_W-1:0]  res_count;
    logic              busy;
    logic              done;
    logic              err;
    logic              dac_en = 1'b1;

    scan_sequencer #(
        .CODE_W     (CODE_W),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC),
        .DAC_TMO    (DAC_TMO)
    ) dut (
        .clock50Mhz  (clk),
        .key_restart (key_restart),
        .cfg_start   (cfg_start),
        .cfg_stop    (cfg_stop),
        .cfg_step    (cfg_step),
        .cfg_window  (cfg_window),
        .start       (start),
        .abort       (abort),
        .dac_code    (dac_code),
        .dac_load    (dac_load),
        .dac_done    (dac_done),
        .cnt_clear   (cnt_clear),
        .cnt_gate    (cnt_gate),
        .cnt_value   (cnt_value),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_code    (res_code),
        .res_count   (res_count),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #10 clk = ~clk;

    // Counter model: three events per gated clock, so a result of 3*window is expected.
    always @(posedge clk) begin
        if (cnt_clear)     cnt_value <= '0;
        else if (cnt_gate) cnt_value <= cnt_value + 32'd3;
    end

    // DAC model: dac_done arrives DAC_DLY clocks after the load request.
    always begin
        @(negedge clk);
        if (dac_load && dac_en) begin
            repeat (DAC_DLY) @(posedge clk);
            #1 dac_done = 1'b1;
            @(posedge clk);
            #1 dac_done = 1'b0;
        end
    end

    int got_code[$];
    int got_count[$];
    int gate_len[$];
    int lat[$];
    int cyc = 0, load_cyc = 0, load_cnt = 0, done_cnt = 0, gate_run = 0, busy_cnt = 0;
    int done_busy_bad = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (dac_load) begin
            load_cnt++;
            load_cyc = cyc;
        end
        if (res_valid && !prev_valid) lat.push_back(cyc - load_cyc);
        prev_valid = res_valid;
        if (res_valid && res_ready) begin
            got_code.push_back(int'(res_code));
            got_count.push_back(int'(res_count));
        end
        if (cnt_gate) begin
            gate_run++;
        end else if (gate_run > 0) begin
            gate_len.push_back(gate_run);
            gate_run = 0;
        end
        if (done) begin
            done_cnt++;
            if (busy) done_busy_bad++;
        end
        if (busy) busy_cnt++;
        cyc++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int start;
        int stop;
        int step;
        int win;
        int exp_n;
        int exp_step;
        int exp_last;
        int exp_win;
        int exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int base_done, input int limit);
        int n = 0;
        while (done_cnt == base_done && n < limit) begin
            @(posedge clk);
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int b_res  = got_code.size();
        int b_gate = gate_len.size();
        int b_load = load_cnt;
        int b_done = done_cnt;
        int n;
        cfg_start  = CODE_W'(v.start);
        cfg_stop   = CODE_W'(v.stop);
        cfg_step   = CODE_W'(v.step);
        cfg_window = CNT_W'(v.win);
        pulse_start();
        wait_done(b_done, 20000);
        repeat (2) @(posedge clk);
        chk("vec_done_pulses", done_cnt - b_done, 1);
        chk("vec_busy_idle", busy, 0);
        chk("vec_err", err, v.exp_err);
        n = got_code.size() - b_res;
        chk("vec_points", n, v.exp_n);
        chk("vec_loads", load_cnt - b_load, v.exp_n);
        chk("vec_gates", gate_len.size() - b_gate, v.exp_n);
        for (int i = 0; i < n && i < v.exp_n; i++) begin
            chk("vec_code", got_code[b_res + i], v.start + i * v.exp_step);
            chk("vec_count", got_count[b_res + i], 3 * v.exp_win);
            if (b_gate + i < gate_len.size())
                chk("vec_gate_len", gate_len[b_gate + i], v.exp_win);
        end
        if (n > 0) chk("vec_last_code", got_code[b_res + n - 1], v.exp_last);
    endtask

    initial begin
        int n, b_load, b_done, b_busy, b_lat, stable_bad;
        int c0, k0;

        vecs[0] = '{100,  103,  1, 10,  4, 1,  103, 10, 0};
        vecs[1] = '{0,    10,   4,  3,  3, 4,    8,  3, 0};
        vecs[2] = '{0,    10,   0,  2, 11, 1,   10,  2, 0};
        vecs[3] = '{4090, 4095, 8,  4,  1, 8, 4090,  4, 0};
        vecs[4] = '{5,    4,    1,  1,  0, 1,    0,  1, 1};
        vecs[5] = '{7,    7,    3,  0,  1, 3,    7,  1, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_outs", {dac_load, cnt_clear, cnt_gate, res_valid, done, err}, 0);
        chk("reset_code", dac_code, 0);
        key_restart = 1'b1;

        // Table-driven scans, with first-point latency checked on the basic one.
        for (int v = 0; v < 6; v++) begin
            b_lat = lat.size();
            run_vec(vecs[v]);
            if (v == 0) begin
                if (lat.size() > b_lat)
                    chk("latency", lat[b_lat], 1 + DAC_DLY + SETTLE_CYC + 1 + 10 + 1);
                else
                    chk("latency_seen", 0, 1);
            end
        end

        // Backpressure on the second point.
        cfg_start = 12'd20; cfg_stop = 12'd23; cfg_step = 12'd1; cfg_window = 32'd4;
        b_load = load_cnt; b_done = done_cnt; n = got_code.size();
        res_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 2000 && got_code.size() == n; i++) @(posedge clk);
        #1 res_ready = 1'b0;
        for (int i = 0; i < 2000 && !res_valid; i++) @(posedge clk);
        @(negedge clk);
        c0 = int'(res_code); k0 = int'(res_count);
        stable_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!res_valid || res_code != CODE_W'(c0) || res_count != CNT_W'(k0) || dac_load)
                stable_bad++;
        end
        chk("bp_stable", stable_bad, 0);
        chk("bp_code", c0, 21);
        chk("bp_count", k0, 12);
        chk("bp_loads", load_cnt - b_load, 2);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_done(b_done, 5000);
        chk("bp_points", got_code.size() - n, 4);
        chk("bp_loads_total", load_cnt - b_load, 4);

        // Abort during the gate window.
        cfg_start = 12'd0; cfg_stop = 12'd5; cfg_window = 32'd30;
        b_load = load_cnt; b_done = done_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && !cnt_gate; i++) @(posedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_gate", cnt_gate, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", res_valid, 0);
        repeat (20) @(posedge clk);
        chk("abort_no_done", done_cnt - b_done, 0);
        chk("abort_err", err, 0);
        chk("abort_loads", load_cnt - b_load, 1);

        // start and abort together in IDLE: nothing starts.
        b_load = load_cnt;
        @(posedge clk);
        #1 start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        repeat (5) @(posedge clk);
        chk("start_abort_loads", load_cnt - b_load, 0);

        // DAC timeout.
        dac_en = 1'b0;
        cfg_start = 12'd1; cfg_stop = 12'd2; cfg_window = 32'd1;
        b_done = done_cnt; b_busy = busy_cnt;
        pulse_start();
        for (int i = 0; i < DAC_TMO + 50 && busy; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_no_done", done_cnt - b_done, 0);
        chk("tmo_busy_cycles", busy_cnt - b_busy, DAC_TMO + 1);
        dac_en = 1'b1;
        repeat (DAC_DLY + 5) @(posedge clk);

        // Asynchronous reset mid-SETTLE, then a fresh scan.
        cfg_start = 12'd100; cfg_stop = 12'd103; cfg_window = 32'd10;
        pulse_start();
        for (int i = 0; i < 2000 && !dac_done; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2 key_restart = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_code", dac_code, 0);
        chk("rst_outs", {dac_load, cnt_clear, cnt_gate, res_valid, done, err}, 0);
        @(posedge clk);
        #1 key_restart = 1'b1;
        repeat (DAC_DLY + 5) @(posedge clk);
        run_vec(vecs[0]);

        chk("done_while_busy", done_busy_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
